// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller.
// Moore FSM that sequences fetch, decode, memory access, ALU execute and
// write-back for lw, sw, R-type, beq, addi and j. Outputs depend only on the
// registered state, the registered R-type ALU decode and the current inputs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   opcode     instruction bits [31:26] from the instruction register
//   funct      instruction bits [5:0] from the instruction register
//   mem_ready  memory access completes this cycle
//   PCWrite .. ALUSrcA, ALUSrcB, PCSrc, outOp   datapath control
//   illegal    one-cycle pulse on an unsupported opcode or funct
//   state      current state encoding (debug)
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory is ready
// DECODE | read registers, precompute branch target
// MEMADR | compute load/store address
// MEMRD  | read data memory, wait for mem_ready
// MEMWB  | write loaded data to rt
// MEMWR  | write data memory, wait for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare and conditionally take branch
// ADDIEX | add sign-extended immediate
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] outOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] alu_op_q;
  logic [2:0] funct_op;
  logic       funct_ok;

  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (funct)
      6'b100000: funct_op = ALU_ADD;
      6'b100010: funct_op = ALU_SUB;
      6'b100100: funct_op = ALU_AND;
      6'b100101: funct_op = ALU_OR;
      6'b101010: funct_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // ALUWB must keep driving the operation decoded in EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  alu_op_q <= ALU_ADD;
    else if (state_q == S_EXEC) alu_op_q <= funct_op;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = funct_ok ? S_ALUWB : S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    outOp    = ALU_ADD;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
          default:                                       illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        outOp   = funct_op;
        illegal = ~funct_ok;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        outOp    = alu_op_q;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        outOp   = ALU_SUB;
        Branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
    // The state register already sits in FETCH during reset, but FETCH
    // would otherwise drive MemRead and (with mem_ready) PCWrite/IRWrite.
    if (!rst) begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSrc    = 2'b00;
      outOp    = ALU_ADD;
      illegal  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. The driver walks each instruction
// through the state list its class must visit, pushing the expected control
// word for every cycle; a monitor pops and compares on the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] outOp;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q[$];
  logic [21:0] dut_w;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .outOp(outOp), .illegal(illegal), .state(state)
  );

  assign dut_w = {state, PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, outOp, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  function automatic bit legal_op(logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
  endfunction

  // {supported, alu op} for an R-type funct field.
  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'd32:   return {1'b1, 3'b010};
      6'd34:   return {1'b1, 3'b110};
      6'd36:   return {1'b1, 3'b000};
      6'd37:   return {1'b1, 3'b001};
      6'd42:   return {1'b1, 3'b111};
      default: return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic logic [21:0] exp_word(logic [3:0] st, logic mr, logic [5:0] op, logic [5:0] fn);
    logic pcw = 0, br = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic rdst = 0, m2r = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] aop = 3'b010;
    logic [3:0] a = alu_of(fn);
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin asb = 2'b11; ill = !legal_op(op); end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin iord = 1; mrd = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iord = 1; mwr = 1; end
      4'd6:  begin asa = 1; aop = a[2:0]; ill = !a[3]; end
      4'd7:  begin rdst = 1; rw = 1; aop = a[2:0]; end
      4'd8:  begin asa = 1; aop = 3'b110; br = 1; pcs = 2'b01; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {st, pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic check(string name, logic [21:0] got, logic [21:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      check($sformatf("ctrl_state%0d", e[21:18]), dut_w, e);
    end
  end

  task automatic cyc(logic mr, logic [3:0] st);
    mem_ready = mr;
    exp_q.push_back(exp_word(st, mr, opcode, funct));
    @(posedge clk);
    #1;
  endtask

  function automatic logic dc(bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // fw/mw: mem_ready-low cycles in FETCH and in the data-memory state.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int fw, int mw, bit rnd);
    opcode = op;
    funct  = fn;
    repeat (fw) cyc(1'b0, 4'd0);
    cyc(1'b1, 4'd0);
    cyc(dc(rnd), 4'd1);
    if (op == LW) begin
      cyc(dc(rnd), 4'd2);
      repeat (mw) cyc(1'b0, 4'd3);
      cyc(1'b1, 4'd3);
      cyc(dc(rnd), 4'd4);
    end else if (op == SW) begin
      cyc(dc(rnd), 4'd2);
      repeat (mw) cyc(1'b0, 4'd5);
      cyc(1'b1, 4'd5);
    end else if (op == RT) begin
      cyc(dc(rnd), 4'd6);
      if (alu_of(fn) >= 4'd8) cyc(dc(rnd), 4'd7);
    end else if (op == BEQ) begin
      cyc(dc(rnd), 4'd8);
    end else if (op == ADDI) begin
      cyc(dc(rnd), 4'd9);
      cyc(dc(rnd), 4'd10);
    end else if (op == JMP) begin
      cyc(dc(rnd), 4'd11);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [21:0] rst_word;
    logic [5:0] fns[5];
    fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37; fns[4] = 6'd42;
    rst_word = {4'd0, 10'b0, 2'b00, 2'b00, 3'b010, 1'b0};

    rst = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;
    #3;
    check("reset_outputs", dut_w, rst_word);
    @(posedge clk); #1;
    check("reset_held", dut_w, rst_word);
    rst = 1'b1;

    run_instr(LW, 6'd0, 0, 0, 0);
    run_instr(RT, 6'd42, 0, 0, 0);
    run_instr(SW, 6'd0, 0, 3, 0);
    run_instr(6'b111111, 6'd0, 0, 0, 0);
    run_instr(BEQ, 6'd0, 0, 0, 0);
    run_instr(JMP, 6'd0, 0, 0, 0);
    run_instr(ADDI, 6'd0, 2, 0, 0);
    run_instr(RT, 6'b000011, 0, 0, 0);

    // Asynchronous reset while waiting in MEMRD.
    opcode = LW; funct = 6'd0;
    cyc(1'b1, 4'd0);
    cyc(1'b1, 4'd1);
    cyc(1'b1, 4'd2);
    cyc(1'b0, 4'd3);
    mem_ready = 1'b0;
    exp_q.push_back(exp_word(4'd3, 1'b0, opcode, funct));
    @(negedge clk); #2;
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("async_rst_memrd", dut_w, rst_word);
    @(posedge clk); #1;
    check("rst_hold_memrd", dut_w, rst_word);
    rst = 1'b1;

    for (int i = 0; i < 250; i++) begin
      int k;
      logic [5:0] op;
      logic [5:0] fn;
      k  = int'($urandom_range(0, 7));
      fn = fns[$urandom_range(0, 4)];
      case (k)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        6: begin
          op = 6'($urandom);
          while (legal_op(op)) op = 6'($urandom);
        end
        default: begin
          op = RT;
          fn = 6'($urandom);
        end
      endcase
      run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 22'(exp_q.size()), 22'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: opcode  input  6  instruction bits [31:26], sampled from the instruction register.
REQ-004 SHALL have port: funct  input  6  instruction bits [5:0], sampled from the instruction register.
REQ-005 SHALL have port: mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL have ports, each output 1 bit: PCWrite, Branch (PC write conditional on zero), IorD (0 = PC address, 1 = ALUOut address), MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA (0 = PC, 1 = reg A).
REQ-007 SHALL have port: ALUSrcB  output  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-008 SHALL have port: PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 SHALL have port: outOp  output  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 SHALL have port: illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-011 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-012 SHALL implement a Moore FSM with states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-013 SHALL drive every output not listed for a state to 0; outOp SHALL default to 010.
REQ-014 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, outOp=010; IRWrite=1 and PCWrite=1 only when mem_ready=1; hold in FETCH while mem_ready=0.
REQ-015 FETCH transitions to DECODE when mem_ready=1.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, outOp=010 (branch target precompute).
REQ-017 DECODE next-state by opcode: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, outOp=010; next state MEMRD for 100011, MEMWR for 101011.
REQ-019 MEMRD: IorD=1, MemRead=1; wait while mem_ready=0; MEMWB on mem_ready=1.
REQ-020 MEMWB: RegDst=0, MemToReg=1, RegWrite=1; next FETCH.
REQ-021 MEMWR: IorD=1, MemWrite=1; wait while mem_ready=0; FETCH on mem_ready=1.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00; outOp from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-023 EXEC with any other funct: outOp=010, illegal=1, next FETCH (no write-back); otherwise next ALUWB.
REQ-024 ALUWB: RegDst=1, MemToReg=0, RegWrite=1, outOp held at the EXEC funct decode; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, outOp=110, Branch=1, PCSrc=01; next FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, outOp=010; next ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemToReg=0, RegWrite=1; next FETCH.
REQ-028 JUMP: PCWrite=1, PCSrc=10; next FETCH.
REQ-029 All outputs SHALL be functions of registered state and current inputs only; no latches.
REQ-030 Unused state encodings 12-15 SHALL transition to FETCH on the next clock with all outputs at default.
REQ-031 Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-032 rst=0 SHALL force state=FETCH immediately, independent of clk, with RegWrite=MemWrite=PCWrite=IRWrite=Branch=illegal=0.
REQ-033 While rst=0, MemRead SHALL be 0.
REQ-034 Reset asserted mid-instruction (any state, including a mem_ready wait) SHALL abort the instruction with no further write strobes.
REQ-035 On rst deassertion, the first rising clk edge SHALL evaluate FETCH normally.

Verification
REQ-036 mem_ready=1, opcode=100011: states 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4.
REQ-037 opcode=000000, funct=101010: states 0,1,6,7,0; outOp=111 in states 6 and 7; RegDst=1 in state 7.
REQ-038 opcode=101011 with mem_ready low for 3 cycles in MEMWR: state 5 held 4 cycles with MemWrite=1 throughout; then FETCH.
REQ-039 opcode=111111: DECODE -> FETCH with illegal=1 for one cycle; no RegWrite or MemWrite pulse.
REQ-040 rst driven to 0 asynchronously during MEMRD: state=0 and all strobes 0 before the next clk edge; after release, FETCH asserts MemRead=1.
REQ-041 opcode=000100 then opcode=000010: beq visits 0,1,8 with Branch=1 and outOp=110; j visits 0,1,11 with PCWrite=1 and PCSrc=10.
